// File: rtl/accum_pkg.sv
// Shared types and helpers for the accumulator result FIFO.
package accum_pkg;

    localparam int unsigned ACC_DATA_W = 8;

    // One stored entry: overflow flag and accumulator result.
    typedef struct packed {
        logic                  ovf;
        logic [ACC_DATA_W-1:0] res;
    } entry_t;

    // Occupancy width: it must be able to hold 0..depth inclusive.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/accum_result_fifo_if.sv
// Producer/consumer bus of the accumulator result FIFO, plus its debug readout.
interface accum_result_fifo_if
    import accum_pkg::*;
#(
    parameter int unsigned DATA_W = ACC_DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
);
    localparam int unsigned LVL_W = lvl_w(DEPTH);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] result;
    logic              overflow_flag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_overflow;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  peak_level;
    logic [CNT_W-1:0]  ovf_count;

    modport master (
        output in_valid, result, overflow_flag, out_ready,
        input  in_ready, out_valid, out_result, out_overflow,
               level, peak_level, ovf_count
    );

    modport slave (
        input  in_valid, result, overflow_flag, out_ready,
        output in_ready, out_valid, out_result, out_overflow,
               level, peak_level, ovf_count
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clr has priority.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/accum_result_fifo.sv
// First-word fall-through FIFO behind the accumulator. It keeps an overflow-event
// count and a peak-occupancy watermark.
module accum_result_fifo
    import accum_pkg::*;
#(
    parameter int unsigned DATA_W = ACC_DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    accum_result_fifo_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = lvl_w(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] peak_q, peak_d;

    logic in_ready_c;
    logic out_valid_c;
    logic push_c;
    logic pop_c;
    entry_t head_c;

    // Handshake flags come only from registered occupancy.
    assign in_ready_c  = (level_q != LVL_W'(DEPTH));
    assign out_valid_c = (level_q != '0);
    assign push_c      = bus.in_valid & in_ready_c;
    assign pop_c       = out_valid_c & bus.out_ready;

    // Next state for the pointers, level and watermark. clr wins over any transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        peak_d   = peak_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            peak_d   = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            peak_d = (level_d > peak_q) ? level_d : peak_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            peak_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            peak_q   <= peak_d;
        end
    end

    // Storage has no reset; reads of stale entries are masked by level.
    always_ff @(posedge clk) begin
        if (push_c && !clr) begin
            mem_q[wr_ptr_q] <= '{ovf: bus.overflow_flag, res: ACC_DATA_W'(bus.result)};
        end
    end

    sat_counter #(.W(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (push_c & bus.overflow_flag),
        .count (bus.ovf_count)
    );

    assign head_c           = mem_q[rd_ptr_q];
    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_c;
    assign bus.out_result   = out_valid_c ? DATA_W'(head_c.res) : '0;
    assign bus.out_overflow = out_valid_c & head_c.ovf;
    assign bus.level        = level_q;
    assign bus.peak_level   = peak_q;

endmodule

// File: tb/tb_accum_result_fifo.sv
// Randomised and directed checks of accum_result_fifo against a queue-based model;
// a second instance with a 2-bit counter shares the stimulus to show saturation.
module tb_accum_result_fifo;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] result = '0;
    logic       overflow_flag = 1'b0;
    logic       out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: stored entries as {ovf, result}, occupancy peak and event counts.
    logic [8:0] mdl_q[$];
    int         mdl_peak = 0;
    int         mdl_ovf8 = 0;
    int         mdl_ovf2 = 0;

    accum_result_fifo_if #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(8)) bus_a ();
    accum_result_fifo_if #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(2)) bus_b ();

    assign bus_a.in_valid      = in_valid;
    assign bus_a.result        = result;
    assign bus_a.overflow_flag = overflow_flag;
    assign bus_a.out_ready     = out_ready;
    assign bus_b.in_valid      = in_valid;
    assign bus_b.result        = result;
    assign bus_b.overflow_flag = overflow_flag;
    assign bus_b.out_ready     = out_ready;

    accum_result_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .clk (clk), .rst (rst), .clr (clr), .bus (bus_a)
    );

    accum_result_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(2)) u_dut_sat (
        .clk (clk), .rst (rst), .clr (clr), .bus (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int         sz;
        logic [8:0] head;
        sz   = mdl_q.size();
        head = (sz > 0) ? mdl_q[0] : 9'h000;
        check("level",        32'(bus_a.level),        32'(sz));
        check("in_ready",     32'(bus_a.in_ready),     32'(sz < DEPTH));
        check("out_valid",    32'(bus_a.out_valid),    32'(sz > 0));
        check("out_result",   32'(bus_a.out_result),   32'(head[7:0]));
        check("out_overflow", 32'(bus_a.out_overflow), 32'(head[8]));
        check("peak_level",   32'(bus_a.peak_level),   32'(mdl_peak));
        check("ovf_count",    32'(bus_a.ovf_count),    32'(mdl_ovf8));
        check("sat_level",    32'(bus_b.level),        32'(sz));
        check("sat_in_ready", 32'(bus_b.in_ready),     32'(sz < DEPTH));
        check("sat_out_valid",32'(bus_b.out_valid),    32'(sz > 0));
        check("sat_out_res",  32'(bus_b.out_result),   32'(head[7:0]));
        check("sat_out_ovf",  32'(bus_b.out_overflow), 32'(head[8]));
        check("sat_peak",     32'(bus_b.peak_level),   32'(mdl_peak));
        check("sat_ovf_count",32'(bus_b.ovf_count),    32'(mdl_ovf2));
    endtask

    // Check outputs between edges, then advance one clock and update the model.
    task automatic cycle();
        bit do_push, do_pop;
        @(negedge clk);
        check_outputs();
        do_push = in_valid && (mdl_q.size() < DEPTH);
        do_pop  = out_ready && (mdl_q.size() > 0);
        @(posedge clk);
        if (clr) begin
            mdl_q.delete();
            mdl_peak = 0;
            mdl_ovf8 = 0;
            mdl_ovf2 = 0;
        end else begin
            if (do_pop) void'(mdl_q.pop_front());
            if (do_push) begin
                mdl_q.push_back({overflow_flag, result});
                if (overflow_flag) begin
                    if (mdl_ovf8 < 255) mdl_ovf8++;
                    if (mdl_ovf2 < 3)   mdl_ovf2++;
                end
            end
            if (mdl_q.size() > mdl_peak) mdl_peak = mdl_q.size();
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] r, input logic o, input logic rdy);
        in_valid      = v;
        result        = r;
        overflow_flag = o;
        out_ready     = rdy;
    endtask

    task automatic do_clr();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset.
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        cycle();

        // Fill to full with the consumer stalled; a fifth offer must be ignored.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i * 16), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        cycle();
        check("full_level", 32'(bus_a.level), 32'd4);
        check("full_peak",  32'(bus_a.peak_level), 32'd4);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (5) cycle();

        // Full with push and pop together: only the pop happens.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 8'hEE, 1'b1, 1'b1);
        cycle();
        check("full_pushpop_level", 32'(bus_a.level), 32'd3);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (4) cycle();

        // Overflow counting, including saturation in the 2-bit instance.
        do_clr();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 1'b1, 1'b1);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        cycle();
        check("ovf_three", 32'(bus_a.ovf_count), 32'd3);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'hD0 + i), 1'b1, 1'b1);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        cycle();
        check("ovf_sat_hold", 32'(bus_b.ovf_count), 32'd3);

        // Streaming: one entry in flight, pointers wrap several times.
        do_clr();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b1);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        cycle();
        cycle();

        // Async reset mid-drain, between edges.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        cycle();
        check("pre_rst_level", 32'(bus_a.level), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid",    32'(bus_a.out_valid),  32'd0);
        check("async_rst_level",    32'(bus_a.level),      32'd0);
        check("async_rst_in_ready", 32'(bus_a.in_ready),   32'd1);
        check("async_rst_peak",     32'(bus_a.peak_level), 32'd0);
        mdl_q.delete();
        mdl_peak = 0;
        mdl_ovf8 = 0;
        mdl_ovf2 = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        cycle();

        // clr with a simultaneous push drops the push.
        drive(1'b1, 8'h99, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 8'h9A, 1'b1, 1'b0);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        check("clr_push_level", 32'(bus_a.level),     32'd0);
        check("clr_push_ovf",   32'(bus_a.ovf_count), 32'd0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0));
            clr = 1'($urandom_range(0, 49) == 0);
            cycle();
        end
        clr = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (6) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
